// File: rtl/bridge_pkg.sv
// bridge_pkg: shared constants for the CPU-to-peripheral bus bridge.
// Default windows, window sizes, read FSM states and device selects.
package bridge_pkg;

  localparam logic [31:0] DEF_TIMER_BASE  = 32'h0000_7F00;
  localparam logic [31:0] DEF_SWITCH_BASE = 32'h0000_7F2C;
  localparam logic [31:0] DEF_LED_BASE    = 32'h0000_7F34;
  localparam logic [31:0] DEF_TUBE_BASE   = 32'h0000_7F38;

  localparam int unsigned TIMER_WORDS  = 3;
  localparam int unsigned SWITCH_WORDS = 2;
  localparam int unsigned LED_WORDS    = 1;
  localparam int unsigned TUBE_WORDS   = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_RESP = 2'd2
  } st_t;

  typedef enum logic [2:0] {
    DEV_NONE   = 3'd0,
    DEV_TIMER  = 3'd1,
    DEV_SWITCH = 3'd2,
    DEV_LED    = 3'd3,
    DEV_TUBE   = 3'd4
  } dev_t;

  function automatic logic in_win(
    input logic [31:0] a,
    input logic [31:0] base,
    input int unsigned words
  );
    logic [31:0] aw;
    logic [31:0] off;
    aw  = {a[31:2], 2'b00};
    off = aw - base;
    return (aw >= base) && (off < (words << 2));
  endfunction

  function automatic logic [1:0] word_of(
    input logic [31:0] a,
    input logic [31:0] base
  );
    logic [31:0] off;
    off = {a[31:2], 2'b00} - base;
    return off[3:2];
  endfunction

endpackage

// File: rtl/bridge_decode.sv
// bridge_decode: maps a byte address onto a device window.
// Produces device select, word index inside the window and a hit flag.
module bridge_decode
  import bridge_pkg::*;
#(
  parameter logic [31:0] TIMER_BASE  = DEF_TIMER_BASE,
  parameter logic [31:0] SWITCH_BASE = DEF_SWITCH_BASE,
  parameter logic [31:0] LED_BASE    = DEF_LED_BASE,
  parameter logic [31:0] TUBE_BASE   = DEF_TUBE_BASE
) (
  input  logic [31:0] addr,
  output dev_t        sel,
  output logic [1:0]  idx,
  output logic        hit
);

  // windows never overlap, so at most one arm matches
  always_comb begin
    sel = DEV_NONE;
    idx = 2'd0;
    hit = 1'b0;
    unique case (1'b1)
      in_win(addr, TIMER_BASE, TIMER_WORDS): begin
        sel = DEV_TIMER;
        idx = word_of(addr, TIMER_BASE);
      end
      in_win(addr, SWITCH_BASE, SWITCH_WORDS): begin
        sel = DEV_SWITCH;
        idx = word_of(addr, SWITCH_BASE);
      end
      in_win(addr, LED_BASE, LED_WORDS): begin
        sel = DEV_LED;
        idx = word_of(addr, LED_BASE);
      end
      in_win(addr, TUBE_BASE, TUBE_WORDS): begin
        sel = DEV_TUBE;
        idx = word_of(addr, TUBE_BASE);
      end
      default: ;
    endcase
    hit = (sel != DEV_NONE);
  end

endmodule

// File: rtl/bus_bridge.sv
// bus_bridge: posted-write / stalled-read bridge from CPU to peripherals.
// Define BRIDGE_BUSERR_EN to drive BusErr; otherwise BusErr is tied low.
module bus_bridge
  import bridge_pkg::*;
#(
  parameter logic [31:0] TIMER_BASE  = DEF_TIMER_BASE,
  parameter logic [31:0] SWITCH_BASE = DEF_SWITCH_BASE,
  parameter logic [31:0] LED_BASE    = DEF_LED_BASE,
  parameter logic [31:0] TUBE_BASE   = DEF_TUBE_BASE
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PrAddr,
  input  logic        PrWE,
  input  logic        PrRE,
  input  logic [3:0]  PrBE,
  input  logic [31:0] PrWD,
  output logic [31:0] PrRD,
  output logic        PrStall,
  output logic [1:0]  DevAddr,
  output logic [3:0]  DevBE,
  output logic [31:0] DevWD,
  output logic        TimerWE,
  output logic        LedWE,
  output logic        TubeWE,
  input  logic [31:0] TimerRD,
  input  logic [31:0] SwitchRD,
  input  logic [31:0] LedRD,
  input  logic [31:0] TubeRD,
  output logic        BusErr
);

  st_t         st_q;
  st_t         st_d;
  dev_t        req_sel;
  dev_t        rd_sel;
  logic [1:0]  req_idx;
  logic [1:0]  rd_idx;
  logic        req_hit;
  logic        rd_hit;
  logic [31:0] rd_addr_q;
  logic [31:0] data_q;
  logic [31:0] rd_mux;
  logic [1:0]  wb_idx_q;
  logic [3:0]  be_q;
  logic [31:0] wd_q;
  logic        tim_we_q;
  logic        led_we_q;
  logic        tube_we_q;
  logic        wb_valid;
  logic        wr_ok;
  logic        wr_take;
  logic        wr_err;
  logic        rd_go;
  logic        stall;

  bridge_decode #(
    .TIMER_BASE (TIMER_BASE),
    .SWITCH_BASE(SWITCH_BASE),
    .LED_BASE   (LED_BASE),
    .TUBE_BASE  (TUBE_BASE)
  ) u_req_dec (
    .addr(PrAddr),
    .sel (req_sel),
    .idx (req_idx),
    .hit (req_hit)
  );

  bridge_decode #(
    .TIMER_BASE (TIMER_BASE),
    .SWITCH_BASE(SWITCH_BASE),
    .LED_BASE   (LED_BASE),
    .TUBE_BASE  (TUBE_BASE)
  ) u_rd_dec (
    .addr(rd_addr_q),
    .sel (rd_sel),
    .idx (rd_idx),
    .hit (rd_hit)
  );

  // the strobe registers double as the one-entry write buffer
  assign wb_valid = tim_we_q | led_we_q | tube_we_q;
  assign wr_ok    = req_hit && (req_sel != DEV_SWITCH);

  // next state, write acceptance and stall request
  always_comb begin
    st_d    = st_q;
    wr_take = 1'b0;
    wr_err  = 1'b0;
    rd_go   = 1'b0;
    stall   = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (PrWE) begin
          wr_take = wr_ok;
          wr_err  = !wr_ok || PrRE;
        end else if (PrRE) begin
          stall = 1'b1;
          if (!wb_valid) begin
            rd_go = 1'b1;
            st_d  = S_RD;
          end
        end
      end
      S_RD: begin
        stall = 1'b1;
        st_d  = S_RESP;
      end
      S_RESP: st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  // read FSM state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) st_q <= S_IDLE;
    else       st_q <= st_d;
  end

  // posted write: load and drain in one step, strobe for one cycle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tim_we_q  <= 1'b0;
      led_we_q  <= 1'b0;
      tube_we_q <= 1'b0;
      wb_idx_q  <= 2'd0;
      be_q      <= 4'h0;
      wd_q      <= 32'h0;
    end else begin
      tim_we_q  <= wr_take && (req_sel == DEV_TIMER);
      led_we_q  <= wr_take && (req_sel == DEV_LED);
      tube_we_q <= wr_take && (req_sel == DEV_TUBE);
      if (wr_take) begin
        wb_idx_q <= req_idx;
        be_q     <= PrBE;
        wd_q     <= PrWD;
      end
    end
  end

  // device read data selected by the latched load address
  always_comb begin
    rd_mux = 32'h0;
    unique case (rd_sel)
      DEV_TIMER:  rd_mux = TimerRD;
      DEV_SWITCH: rd_mux = SwitchRD;
      DEV_LED:    rd_mux = LedRD;
      DEV_TUBE:   rd_mux = TubeRD;
      default:    rd_mux = 32'h0;
    endcase
  end

  // latch load address in IDLE, capture device data in RD
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_addr_q <= 32'h0;
      data_q    <= 32'h0;
    end else begin
      if (rd_go) rd_addr_q <= PrAddr;
      if (st_q == S_RD) data_q <= rd_hit ? rd_mux : 32'h0;
    end
  end

  assign PrRD    = data_q;
  assign PrStall = stall & ~Reset;
  assign DevAddr = (st_q == S_RD) ? rd_idx : wb_idx_q;
  assign DevBE   = be_q;
  assign DevWD   = wd_q;
  assign TimerWE = tim_we_q;
  assign LedWE   = led_we_q;
  assign TubeWE  = tube_we_q;

`ifdef BRIDGE_BUSERR_EN
  logic err_q;

  // dropped or conflicting writes flag one cycle after acceptance
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) err_q <= 1'b0;
    else       err_q <= wr_err;
  end

  assign BusErr = err_q | ((st_q == S_RD) && !rd_hit);
`else
  logic unused_err;
  assign unused_err = wr_err;
  assign BusErr     = 1'b0;
`endif

endmodule

// File: tb/tb_bus_bridge.sv
// tb_bus_bridge: directed bench for bus_bridge with a timeline model.
// Model tracks posted writes, load timing, BusErr and device contents.
module tb_bus_bridge;

  logic        Clk;
  logic        Reset;
  logic [31:0] PrAddr;
  logic        PrWE;
  logic        PrRE;
  logic [3:0]  PrBE;
  logic [31:0] PrWD;
  logic [31:0] PrRD;
  logic        PrStall;
  logic [1:0]  DevAddr;
  logic [3:0]  DevBE;
  logic [31:0] DevWD;
  logic        TimerWE;
  logic        LedWE;
  logic        TubeWE;
  logic [31:0] TimerRD;
  logic [31:0] SwitchRD;
  logic [31:0] LedRD;
  logic [31:0] TubeRD;
  logic        BusErr;

  int checks = 0;
  int errors = 0;

  bus_bridge dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .PrAddr  (PrAddr),
    .PrWE    (PrWE),
    .PrRE    (PrRE),
    .PrBE    (PrBE),
    .PrWD    (PrWD),
    .PrRD    (PrRD),
    .PrStall (PrStall),
    .DevAddr (DevAddr),
    .DevBE   (DevBE),
    .DevWD   (DevWD),
    .TimerWE (TimerWE),
    .LedWE   (LedWE),
    .TubeWE  (TubeWE),
    .TimerRD (TimerRD),
    .SwitchRD(SwitchRD),
    .LedRD   (LedRD),
    .TubeRD  (TubeRD),
    .BusErr  (BusErr)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // simple peripheral devices
  logic [31:0] timer_mem [4];
  logic [31:0] tube_mem [4];
  logic [31:0] led_mem;

  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 4; i++) begin
        timer_mem[i] <= 32'h0;
        tube_mem[i]  <= 32'h0;
      end
      led_mem <= 32'h0;
    end else begin
      if (TimerWE) timer_mem[DevAddr] <= merge(timer_mem[DevAddr], DevWD, DevBE);
      if (TubeWE)  tube_mem[DevAddr]  <= merge(tube_mem[DevAddr], DevWD, DevBE);
      if (LedWE)   led_mem            <= merge(led_mem, DevWD, DevBE);
    end
  end

  assign TimerRD  = timer_mem[DevAddr];
  assign TubeRD   = tube_mem[DevAddr];
  assign LedRD    = led_mem;
  assign SwitchRD = (DevAddr == 2'd1) ? 32'h0000_00A5 : 32'h0000_005A;

  // model: 0 none, 1 timer, 2 switch, 3 led, 4 tube
  function automatic int dev_of(input logic [31:0] a, output logic [1:0] ix);
    logic [31:0] base [4];
    int          n [4];
    base = '{32'h7F00, 32'h7F2C, 32'h7F34, 32'h7F38};
    n    = '{3, 2, 1, 2};
    ix = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (a >= base[k] && a < base[k] + 32'(4 * n[k])) begin
        ix = 2'((a - base[k]) / 4);
        return k + 1;
      end
    end
    return 0;
  endfunction

  logic [31:0] m_timer [4];
  logic [31:0] m_tube [4];
  logic [31:0] m_led;
  logic [31:0] m_rd;
  bit          err_due [int];
  bit          model_on;
  int          cyc;
  int          ld_start;
  logic [1:0]  ld_ix;
  logic [31:0] ld_val;
  bit          w_valid;
  int          w_cyc;
  int          w_dev;
  logic [1:0]  w_ix;
  logic [3:0]  w_be;
  logic [31:0] w_wd;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_timer[i] = 32'h0;
      m_tube[i]  = 32'h0;
    end
    m_led    = 32'h0;
    m_rd     = 32'h0;
    ld_start = -1;
    w_valid  = 1'b0;
    err_due.delete();
  endtask

  function automatic logic [31:0] model_read(input int dv, input logic [1:0] ix);
    case (dv)
      1: return m_timer[ix];
      2: return (ix == 2'd1) ? 32'h0000_00A5 : 32'h0000_005A;
      3: return m_led;
      4: return m_tube[ix];
      default: return 32'h0;
    endcase
  endfunction

  bit          cur_w;
  bit          busy;
  logic [2:0]  e_we;
  logic        e_err;
  logic        e_stall;
  logic [1:0]  c_ix;
  logic [3:0]  c_be;
  logic [31:0] c_wd;
  logic [1:0]  mix;
  int          dv;

  // per-cycle compare against the model
  always @(negedge Clk) begin
    if (model_on && !Reset) begin
      cur_w = w_valid && (w_cyc == cyc);
      e_we  = 3'b000;
      c_ix  = w_ix;
      c_be  = w_be;
      c_wd  = w_wd;
      if (cur_w) begin
        case (w_dev)
          1: e_we = 3'b001;
          3: e_we = 3'b010;
          4: e_we = 3'b100;
          default: e_we = 3'b000;
        endcase
      end
`ifdef BRIDGE_BUSERR_EN
      e_err = err_due.exists(cyc);
`else
      e_err = 1'b0;
`endif
      busy = (ld_start >= 0) && (cyc > ld_start) && (cyc <= ld_start + 2);
      e_stall = 1'b0;
      if (busy) begin
        if (cyc == ld_start + 1) e_stall = 1'b1;
        else m_rd = ld_val;
      end else if (PrWE) begin
        dv = dev_of(PrAddr, mix);
        if (dv == 1 || dv == 3 || dv == 4) begin
          case (dv)
            1: m_timer[mix] = merge(m_timer[mix], PrWD, PrBE);
            3: m_led = merge(m_led, PrWD, PrBE);
            default: m_tube[mix] = merge(m_tube[mix], PrWD, PrBE);
          endcase
          w_valid = 1'b1;
          w_cyc   = cyc + 1;
          w_dev   = dv;
          w_ix    = mix;
          w_be    = PrBE;
          w_wd    = PrWD;
        end else begin
          err_due[cyc + 1] = 1'b1;
        end
        if (PrRE) err_due[cyc + 1] = 1'b1;
      end else if (PrRE) begin
        e_stall = 1'b1;
        if (!cur_w) begin
          dv       = dev_of(PrAddr, mix);
          ld_start = cyc;
          ld_ix    = mix;
          ld_val   = model_read(dv, mix);
          if (dv == 0) err_due[cyc + 1] = 1'b1;
        end
      end
      chk("stall", 32'(PrStall), 32'(e_stall));
      chk("we", 32'({TubeWE, LedWE, TimerWE}), 32'(e_we));
      chk("buserr", 32'(BusErr), 32'(e_err));
      chk("prrd", PrRD, m_rd);
      if (cur_w) begin
        chk("wr_addr", 32'(DevAddr), 32'(c_ix));
        chk("wr_be", 32'(DevBE), 32'(c_be));
        chk("wr_wd", DevWD, c_wd);
      end
      if (busy && cyc == ld_start + 1)
        chk("rd_addr", 32'(DevAddr), 32'(ld_ix));
      cyc++;
    end
  end

  task automatic step(input logic we, input logic re, input logic [31:0] a,
                      input logic [3:0] be, input logic [31:0] wd);
    @(posedge Clk);
    #1;
    PrWE   = we;
    PrRE   = re;
    PrAddr = a;
    PrBE   = be;
    PrWD   = wd;
  endtask

  task automatic load(input logic [31:0] a, output int ns,
                      output logic [31:0] d);
    bit done;
    ns   = 0;
    d    = 32'h0;
    done = 1'b0;
    step(1'b0, 1'b1, a, 4'h0, 32'h0);
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge Clk);
      if (PrStall) begin
        ns++;
        @(posedge Clk);
        #1;
      end else begin
        d    = PrRD;
        done = 1'b1;
      end
    end
    if (!done) chk("load_timeout", 32'(ns), 32'hFFFF_FFFF);
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  int          ns;
  logic [31:0] d;

  initial begin
    model_on = 1'b0;
    cyc      = 0;
    model_reset();
    Reset  = 1'b1;
    PrAddr = 32'h0;
    PrWE   = 1'b0;
    PrRE   = 1'b0;
    PrBE   = 4'h0;
    PrWD   = 32'h0;
    #3;
    chk("rst_stall", 32'(PrStall), 32'h0);
    chk("rst_we", 32'({TubeWE, LedWE, TimerWE}), 32'h0);
    chk("rst_devaddr", 32'(DevAddr), 32'h0);
    chk("rst_devbe", 32'(DevBE), 32'h0);
    chk("rst_devwd", DevWD, 32'h0);
    chk("rst_prrd", PrRD, 32'h0);
    chk("rst_buserr", 32'(BusErr), 32'h0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    model_on = 1'b1;

    // tube word 1 write
    step(1'b1, 1'b0, 32'h7F3C, 4'hF, 32'h1234_5678);
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge Clk);
    chk("tube_we_n1", 32'(TubeWE), 32'h1);
    chk("tube_addr_n1", 32'(DevAddr), 32'h1);
    chk("tube_wd_n1", DevWD, 32'h1234_5678);
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge Clk);
    chk("tube_we_n2", 32'(TubeWE), 32'h0);

    // back-to-back timer then LED
    step(1'b1, 1'b0, 32'h7F00, 4'hF, 32'h1111_1111);
    step(1'b1, 1'b0, 32'h7F34, 4'h3, 32'hAAAA_BBBB);
    @(negedge Clk);
    chk("b2b_timer_we", 32'(TimerWE), 32'h1);
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge Clk);
    chk("b2b_led_we", 32'(LedWE), 32'h1);

    // partial byte write to timer word 2
    step(1'b1, 1'b0, 32'h7F08, 4'b0101, 32'hDEAD_BEEF);

    // write then immediate load of tube word 0
    step(1'b1, 1'b0, 32'h7F38, 4'hF, 32'hCAFE_F00D);
    load(32'h7F38, ns, d);
    chk("wr_rd_stalls", 32'(ns), 32'd3);
    chk("wr_rd_data", d, 32'hCAFE_F00D);

    load(32'h7F30, ns, d);
    chk("sw_stalls", 32'(ns), 32'd2);
    chk("sw_data", d, 32'h0000_00A5);

    load(32'h7F0B, ns, d);
    chk("timer2_data", d, 32'h00AD_00EF);

    load(32'h7F34, ns, d);
    chk("led_data", d, 32'h0000_BBBB);

    // dropped writes and unmapped loads
    step(1'b1, 1'b0, 32'h7F2C, 4'hF, 32'h5555_5555);
    step(1'b1, 1'b0, 32'h7F0C, 4'hF, 32'h6666_6666);
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    load(32'h8000, ns, d);
    chk("unmapped_stalls", 32'(ns), 32'd2);
    chk("unmapped_data", d, 32'h0);
    load(32'h7F3C, ns, d);
    chk("tube1_data", d, 32'h1234_5678);
    load(32'h7F40, ns, d);
    chk("past_tube_data", d, 32'h0);

    // write and read together: write wins
    step(1'b1, 1'b1, 32'h7F34, 4'hF, 32'h0000_0077);
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    load(32'h7F34, ns, d);
    chk("led_after_wr_rd", d, 32'h0000_0077);

    // reset in the middle of a load
    step(1'b0, 1'b1, 32'h7F30, 4'h0, 32'h0);
    @(posedge Clk);
    #2;
    model_on = 1'b0;
    Reset = 1'b1;
    #1;
    chk("mid_rst_stall", 32'(PrStall), 32'h0);
    chk("mid_rst_we", 32'({TubeWE, LedWE, TimerWE}), 32'h0);
    chk("mid_rst_devaddr", 32'(DevAddr), 32'h0);
    chk("mid_rst_devbe", 32'(DevBE), 32'h0);
    chk("mid_rst_devwd", DevWD, 32'h0);
    chk("mid_rst_prrd", PrRD, 32'h0);
    chk("mid_rst_buserr", 32'(BusErr), 32'h0);
    PrRE = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    @(posedge Clk);
    #1;
    model_on = 1'b1;
    load(32'h7F2C, ns, d);
    chk("post_rst_stalls", 32'(ns), 32'd2);
    chk("post_rst_data", d, 32'h0000_005A);
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
